// File: rtl/n8_pkg.sv
// Shared types and constants for the N8 serial controller reader.
// Bit indices follow the order the controller shifts buttons out after a latch.
package n8_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int NUM_BUTTONS = 8;

  localparam int BIT_A      = 0;
  localparam int BIT_B      = 1;
  localparam int BIT_SELECT = 2;
  localparam int BIT_START  = 3;
  localparam int BIT_UP     = 4;
  localparam int BIT_DOWN   = 5;
  localparam int BIT_LEFT   = 6;
  localparam int BIT_RIGHT  = 7;

endpackage

// File: rtl/n8_sync.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle line can start in its inactive level.
module n8_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/n8_controller_reader.sv
// Polls an N8/NES serial controller at a fixed rate and publishes the eight
// button levels (active-high) atomically once per completed frame.
module n8_controller_reader
  import n8_pkg::*;
#(
  parameter int POLL_CYCLES  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic n8_data,
  output logic n8_latch,
  output logic n8_clk,
  output logic a,
  output logic b,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic frame_valid
);

  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [2:0]        IDX_LAST   = 3'(NUM_BUTTONS - 1);

  logic                   data_s;
  logic [POLL_W-1:0]      poll_cnt;
  logic                   tick;
  state_t                 state;
  logic [PH_W-1:0]        phase;
  logic [2:0]             bit_idx;
  logic [NUM_BUTTONS-1:0] shreg;
  logic [NUM_BUTTONS-1:0] btn;

  n8_sync #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (n8_data),
    .q   (data_s)
  );

  // Free-running poll timer; the wrap edge starts a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  assign tick = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      btn         <= '0;
      n8_latch    <= 1'b0;
      n8_clk      <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= LATCH;
            phase    <= '0;
            n8_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            state    <= LOW;
            phase    <= '0;
            bit_idx  <= '0;
            n8_latch <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        // Sample on the last low cycle, giving the synchronised bit time to settle.
        LOW: begin
          if (phase == HALF_LAST) begin
            phase          <= '0;
            shreg[bit_idx] <= ~data_s;
            if (bit_idx == IDX_LAST) begin
              state <= DONE;
            end else begin
              state  <= HIGH;
              n8_clk <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == HALF_LAST) begin
            state   <= LOW;
            phase   <= '0;
            n8_clk  <= 1'b0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          btn         <= shreg;
          frame_valid <= 1'b1;
          state       <= IDLE;
          phase       <= '0;
        end
        default: begin
          state <= IDLE;
          phase <= '0;
        end
      endcase
    end
  end

  assign a      = btn[BIT_A];
  assign b      = btn[BIT_B];
  assign select = btn[BIT_SELECT];
  assign start  = btn[BIT_START];
  assign up     = btn[BIT_UP];
  assign down   = btn[BIT_DOWN];
  assign left   = btn[BIT_LEFT];
  assign right  = btn[BIT_RIGHT];

endmodule

// File: tb/tb_n8_controller_reader.sv
// Bench for n8_controller_reader: a serial controller model feeds patterns and a
// frame-timing model predicts every output on every cycle.
module tb_n8_controller_reader;

  localparam int POLL  = 200;
  localparam int LATCH = 6;
  localparam int HALF  = 4;
  localparam int FV_O  = LATCH + 15 * HALF + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n8_data;
  logic n8_latch, n8_clk, frame_valid;
  logic a, b, select, start, up, down, left, right;
  logic [7:0] btn_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n8_controller_reader #(
    .POLL_CYCLES (POLL),
    .LATCH_CYCLES(LATCH),
    .HALF_CYCLES (HALF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .n8_data    (n8_data),
    .n8_latch   (n8_latch),
    .n8_clk     (n8_clk),
    .a          (a),
    .b          (b),
    .select     (select),
    .start      (start),
    .up         (up),
    .down       (down),
    .left       (left),
    .right      (right),
    .frame_valid(frame_valid)
  );

  assign btn_vec = {right, left, down, up, start, select, b, a};

  // Controller model: active-low pattern, bit 0 after latch fall, advance on clock rise.
  logic [7:0] pattern  = 8'hFE;
  logic       hold_en  = 1'b0;
  logic       hold_val = 1'b1;
  logic       ctrl_bit = 1'b1;
  int         cidx     = 0;

  always @(negedge n8_latch) begin
    cidx     = 0;
    ctrl_bit = pattern[0];
  end

  always @(posedge n8_clk) begin
    cidx     = cidx + 1;
    ctrl_bit = (cidx < 8) ? pattern[cidx[2:0]] : 1'b1;
  end

  assign n8_data = hold_en ? hold_val : ctrl_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-timing model: n counts clock edges since reset release.
  int         n = 0;
  logic [7:0] exp_btn = 8'h00;
  logic [7:0] pend    = 8'h00;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  always @(negedge clk) begin
    int  o;
    bit  inf;
    if (rst) begin
      exp_btn = 8'h00;
      chk("m_rst_latch", n8_latch, 0);
      chk("m_rst_clk", n8_clk, 0);
      chk("m_rst_fv", frame_valid, 0);
      chk("m_rst_btn", btn_vec, 0);
    end else begin
      o   = n % POLL;
      inf = (n >= POLL);
      if (inf && o == LATCH) pend = hold_en ? {8{~hold_val}} : ~pattern;
      if (inf && o == FV_O) exp_btn = pend;
      chk("m_latch", n8_latch, 32'(inf && o < LATCH));
      chk("m_clk", n8_clk, 32'(inf && o >= LATCH && o < LATCH + 15 * HALF &&
                                ((o - LATCH) / HALF) % 2 == 1));
      chk("m_fv", frame_valid, 32'(inf && o == FV_O));
      chk("m_btn", btn_vec, exp_btn);
    end
  end

  task automatic wait_fv(input string name, output logic [7:0] prev);
    prev = btn_vec;
    for (int i = 0; i < 2 * POLL; i++) begin
      @(negedge clk);
      if (frame_valid) return;
      prev = btn_vec;
    end
    chk({name, "_fv_timeout"}, 0, 1);
  endtask

  task automatic wait_latch_rise(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!n8_latch && cyc < 2 * POLL);
  endtask

  initial begin
    logic [7:0] prev;
    int cyc, lat_w, rises, hi_cnt, fv_o, fv_cnt;
    logic pclk;

    // Reset and startup timing, first frame pattern A pressed.
    repeat (10) @(negedge clk);
    chk("t1_rst_latch", n8_latch, 0);
    chk("t1_rst_btn", btn_vec, 0);
    #1 rst = 1'b0;
    wait_latch_rise("t1", cyc);
    chk("t1_latch_rise_cyc", cyc, 200);
    lat_w = 1; rises = 0; hi_cnt = 0; fv_o = -1; fv_cnt = 0; pclk = 1'b0;
    for (int o = 1; o <= 80; o++) begin
      @(negedge clk);
      if (n8_latch) lat_w++;
      if (n8_clk && !pclk) rises++;
      if (n8_clk) hi_cnt++;
      if (frame_valid) begin fv_o = o; fv_cnt++; end
      pclk = n8_clk;
    end
    chk("t1_latch_width", lat_w, 6);
    chk("t1_clk_pulses", rises, 7);
    chk("t1_clk_high_cycles", hi_cnt, 28);
    chk("t1_fv_offset", fv_o, 67);
    chk("t1_fv_width", fv_cnt, 1);
    chk("t2_a_only", btn_vec, 8'h01);

    // Up + Left, then all released.
    pattern = 8'b1010_1111;
    wait_fv("t3a", prev);
    chk("t3a_prev_hold", prev, 8'h01);
    chk("t3a_up_left", btn_vec, 8'h50);
    @(negedge clk);
    chk("t3a_fv_one_cycle", frame_valid, 0);
    pattern = 8'hFF;
    wait_fv("t3b", prev);
    chk("t3b_prev_hold", prev, 8'h50);
    chk("t3b_released", btn_vec, 8'h00);

    // Opposing directions are both reported.
    pattern = 8'b1100_1111;
    wait_fv("t4a", prev);
    chk("t4a_up_down", btn_vec, 8'h30);
    pattern = 8'b0011_1111;
    wait_fv("t4b", prev);
    chk("t4b_left_right", btn_vec, 8'hC0);

    // Data line held constant.
    hold_en = 1'b1; hold_val = 1'b0;
    wait_fv("t5a", prev);
    chk("t5a_all_pressed", btn_vec, 8'hFF);
    hold_val = 1'b1;
    wait_fv("t5b", prev);
    chk("t5b_none_pressed", btn_vec, 8'h00);
    hold_en = 1'b0;

    pattern = 8'h5A;
    wait_fv("t6pre", prev);
    chk("t6_pre_btn", btn_vec, 8'hA5);

    // Reset during the high phase of bit 3.
    pattern = 8'h00;
    wait_latch_rise("t6", cyc);
    rises = 0; pclk = 1'b0; cyc = 0;
    while (rises < 4 && cyc < POLL) begin
      @(negedge clk);
      cyc++;
      if (n8_clk && !pclk) rises++;
      pclk = n8_clk;
    end
    chk("t6_in_bit3_high", n8_clk, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_clk", n8_clk, 0);
    chk("t6_async_latch", n8_latch, 0);
    chk("t6_async_btn", btn_vec, 0);
    chk("t6_async_fv", frame_valid, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    pattern = 8'h7E;
    wait_latch_rise("t6post", cyc);
    chk("t6_latch_rise_cyc", cyc, 200);
    wait_fv("t6post", prev);
    chk("t6_no_stale_btn", prev, 8'h00);
    chk("t6_fresh_a_right", btn_vec, 8'h81);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0t want below 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
